// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions for the burst masters.
//   BURST_INCR, RESP_* : AXI encodings
//   AXI_4K_BYTES       : page size a burst must not cross
//   size_from_width()  : AxSIZE from a data width in bits
//   rd_state_t         : read master state encoding
package axi4_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int AXI_4K_BYTES = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } rd_state_t;

    // log2 of the bytes per beat; widths outside 8..1024 fall back to 0
    function automatic logic [2:0] size_from_width(input int data_width);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((8 << i) == data_width) s = 3'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/axi4_burst_calc.sv
// Combinational INCR burst sizing.
//   addr_lo : low 12 bits of the burst start address (offset in 4 KB page)
//   rem     : beats still to be requested
//   len     : beats in this burst = min(rem, MAX_BURST_LEN, beats left in page)
//   arlen   : len - 1 (meaningless when rem is 0)
module axi4_burst_calc
    import axi4_pkg::*;
#(
    parameter int LEN_WIDTH     = 16,
    parameter int MAX_BURST_LEN = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic [11:0]          addr_lo,
    input  logic [LEN_WIDTH-1:0] rem,
    output logic [8:0]           len,
    output logic [7:0]           arlen
);

    localparam logic [2:0] SIZE = size_from_width(DATA_WIDTH);
    // wide enough for both the command count and a full page of byte beats
    localparam int CW = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

    logic [CW-1:0] rem_w;
    logic [CW-1:0] page_w;
    logic [CW-1:0] cap_w;
    logic [CW-1:0] len_w;

    always_comb begin
        rem_w  = CW'(rem);
        page_w = CW'(13'(AXI_4K_BYTES) - {1'b0, addr_lo}) >> SIZE;
        cap_w  = CW'(MAX_BURST_LEN);
        len_w  = rem_w;
        if (cap_w < len_w) len_w = cap_w;
        if (page_w < len_w) len_w = page_w;
    end

    assign len   = 9'(len_w);
    assign arlen = 8'(len_w - CW'(1));

endmodule

// File: rtl/axi4_burst_reader.sv
// AXI4 read-burst master: one (address, beat count) command becomes a
// sequence of INCR bursts, capped at MAX_BURST_LEN and never crossing 4 KB.
// Returned data is passed straight through to a ready/valid stream.
//   cmd_*      : command handshake from the load controller
//   m_axi_ar*  : AR channel (single outstanding burst, ARID = 0)
//   m_axi_r*   : R channel; rready follows m_ready while a burst is open
//   m_data/m_valid/m_ready/m_last : output stream, m_last on final beat
//   busy, done (1-cycle pulse), error (sticky until next command)
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for a command, cmd_ready high
// ADDR    | AR payload registered, arvalid high
// DATA    | forwarding R beats of the current burst
// DONE    | one-cycle completion pulse
module axi4_burst_reader
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 1,
    parameter int MAX_BURST_LEN = 16,
    parameter int LEN_WIDTH     = 16
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_areset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_beats,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,

    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [2:0] SIZE = size_from_width(DATA_WIDTH);

    rd_state_t state, state_n;

    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [LEN_WIDTH-1:0]  rem_dec;
    logic [LEN_WIDTH-1:0]  calc_rem;
    logic [8:0]            len_q;
    logic [8:0]            beat_cnt;
    logic [8:0]            beat_dec;
    logic [8:0]            calc_len;
    logic [7:0]            arlen_q;
    logic [7:0]            calc_arlen;
    logic                  error_q;
    logic                  r_hs;
    logic                  load_ar;
    logic                  beat_err;
    logic                  rid_unused;

    // rid carries nothing useful with a single outstanding burst
    assign rid_unused = ^m_axi_rid;

    assign r_hs     = (state == ST_DATA) && m_axi_rvalid && m_ready;
    // saturate so a misbehaving slave cannot wrap the counters
    assign rem_dec  = (rem_q == '0) ? rem_q : rem_q - LEN_WIDTH'(1);
    assign beat_dec = (beat_cnt == 9'd0) ? beat_cnt : beat_cnt - 9'd1;
    assign beat_err = (m_axi_rresp != RESP_OKAY)
                    || (m_axi_rlast && (beat_cnt != 9'd1))
                    || (!m_axi_rlast && (beat_cnt == 9'd1));

    // The next burst is sized in the same cycle the AR payload is loaded,
    // either from the new command or from the burst that just finished.
    assign next_addr = araddr_q + (ADDR_WIDTH'(len_q) << SIZE);
    assign calc_addr = (state == ST_IDLE) ? cmd_addr : next_addr;
    assign calc_rem  = (state == ST_IDLE) ? cmd_beats : rem_dec;
    assign load_ar   = (state_n == ST_ADDR) && (state != ST_ADDR);

    axi4_burst_calc #(
        .LEN_WIDTH     (LEN_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_calc (
        .addr_lo (calc_addr[11:0]),
        .rem     (calc_rem),
        .len     (calc_len),
        .arlen   (calc_arlen)
    );

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        cmd_ready     = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_valid       = 1'b0;
        m_last        = 1'b0;
        done          = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_n = (cmd_beats == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_n = ST_DATA;
            end
            ST_DATA: begin
                m_valid      = m_axi_rvalid;
                m_axi_rready = m_ready;
                m_last       = m_axi_rvalid && (rem_q == LEN_WIDTH'(1));
                if (r_hs && m_axi_rlast) begin
                    state_n = (rem_dec == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            araddr_q <= '0;
            arlen_q  <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            beat_cnt <= '0;
            error_q  <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && cmd_valid) begin
                rem_q   <= cmd_beats;
                error_q <= 1'b0;
            end
            if (load_ar) begin
                araddr_q <= calc_addr;
                arlen_q  <= calc_arlen;
                len_q    <= calc_len;
            end
            if ((state == ST_ADDR) && m_axi_arready) begin
                beat_cnt <= len_q;
            end
            if (r_hs) begin
                rem_q    <= rem_dec;
                beat_cnt <= beat_dec;
                if (beat_err) error_q <= 1'b1;
            end
        end
    end

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = SIZE;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_data        = m_axi_rdata;
    assign busy          = (state != ST_IDLE);
    assign error         = error_q;

endmodule

// File: tb/tb_axi4_burst_reader.sv
module tb_axi4_burst_reader;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 1;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_beats = '0;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [IW-1:0] rid = '0;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = 2'b00;
    logic          rlast = 1'b0;
    logic          rvalid = 1'b0;
    logic          rready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          busy, done, error;

    axi4_burst_reader dut (
        .m_axi_aclk(clk), .m_axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done), .error(error)
    );

    int checks = 0;
    int failures = 0;

    // model of the expected behaviour
    bit          mb_busy, mb_arp, mb_dp, mb_done, mb_err;
    int          mb_rem, mb_bcnt;
    logic [31:0] ar_addr_q[$];
    int          ar_len_q[$];
    logic [31:0] stream_q[$];

    // slave and traffic knobs
    bit          s_active;
    logic [31:0] s_addr;
    int          s_left, s_beat;
    int          err_beat = -1;
    int          rv_pct = 100, mr_pct = 100, ar_pct = 100;

    // observation log
    logic [31:0] log_addr[$];
    int          log_len[$];
    int          lasts, beats_seen, acc_cnt, done_cnt, cyc, acc_cyc, done_cyc;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        mb_busy = 0; mb_arp = 0; mb_dp = 0; mb_done = 0; mb_err = 0;
        mb_rem = 0; mb_bcnt = 0;
        ar_addr_q.delete(); ar_len_q.delete(); stream_q.delete();
        s_active = 0; s_left = 0;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
    endtask

    // compare process + slave + model update
    initial begin : cmp
        bit          e_cmd, e_ar, e_r, e_rlast, rs;
        logic [1:0]  e_resp;
        logic [31:0] e_caddr, e_araddr, a;
        int          e_cbeats, e_arlen, r, l, pg;
        clear_model();
        forever begin
            @(negedge clk);
            cyc++;
            e_cmd = 0; e_ar = 0; e_r = 0; e_rlast = 0; e_resp = 2'b00;
            rs = rst;
            if (!rst) begin
                chk("busy", busy, mb_busy);
                chk("cmd_ready", cmd_ready, !mb_busy);
                chk("done", done, mb_done);
                chk("error", error, mb_err);
                chk("arvalid", arvalid, mb_arp);
                if (arvalid) begin
                    if (ar_addr_q.size() > 0) begin
                        chk("araddr", araddr, ar_addr_q[0]);
                        chk("arlen", arlen, 64'(ar_len_q[0] - 1));
                        chk("ar_fixed", {arid, arsize, arburst, arcache, arprot},
                            {1'b0, 3'd2, 2'b01, 4'b0011, 3'b000});
                    end else begin
                        chk("ar_unexpected", ar_addr_q.size(), 1);
                    end
                end
                chk("m_valid", m_valid, mb_dp && rvalid);
                chk("rready", rready, mb_dp && m_ready);
                chk("m_last", m_last, mb_dp && rvalid && (stream_q.size() == 1));
                if (m_valid) chk("m_data_pass", m_data, rdata);
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (cmd_valid && cmd_ready) begin
                    e_cmd = 1; e_caddr = cmd_addr; e_cbeats = int'(cmd_beats);
                    acc_cnt++; acc_cyc = cyc;
                end
                if (arvalid && arready) begin
                    e_ar = 1; e_araddr = araddr; e_arlen = int'(arlen);
                    log_addr.push_back(araddr); log_len.push_back(int'(arlen));
                end
                if (rvalid && rready) begin
                    e_r = 1; e_rlast = rlast; e_resp = rresp;
                    if (stream_q.size() > 0) chk("stream_data", m_data, stream_q[0]);
                    else chk("stream_extra", stream_q.size(), 1);
                    if (m_last) lasts++;
                end
            end
            @(posedge clk); #1;
            if (rs || rst) begin
                clear_model();
            end else begin
                if (mb_done) begin mb_done = 0; mb_busy = 0; end
                if (e_cmd) begin
                    mb_busy = 1; mb_err = 0; mb_rem = e_cbeats;
                    s_beat = 0; beats_seen = 0;
                    ar_addr_q.delete(); ar_len_q.delete(); stream_q.delete();
                    a = e_caddr; r = e_cbeats;
                    while (r > 0) begin
                        l = (r > 16) ? 16 : r;
                        pg = (4096 - int'(a[11:0])) / 4;
                        if (pg < l) l = pg;
                        ar_addr_q.push_back(a); ar_len_q.push_back(l);
                        a = a + 32'(l * 4); r = r - l;
                    end
                    for (int i = 0; i < e_cbeats; i++) stream_q.push_back(mem(e_caddr + 32'(4 * i)));
                    if (e_cbeats == 0) mb_done = 1; else mb_arp = 1;
                end
                if (e_ar) begin
                    mb_arp = 0; mb_dp = 1;
                    if (ar_len_q.size() > 0) begin
                        mb_bcnt = ar_len_q[0];
                        void'(ar_addr_q.pop_front()); void'(ar_len_q.pop_front());
                    end
                    s_active = 1; s_addr = e_araddr; s_left = e_arlen + 1;
                end
                if (e_r) begin
                    if (stream_q.size() > 0) void'(stream_q.pop_front());
                    mb_rem--; beats_seen++;
                    if (e_resp != 2'b00) mb_err = 1;
                    if (e_rlast && mb_bcnt != 1) mb_err = 1;
                    if (!e_rlast && mb_bcnt == 1) mb_err = 1;
                    mb_bcnt--;
                    if (e_rlast) begin
                        mb_dp = 0;
                        if (mb_rem == 0) mb_done = 1; else mb_arp = 1;
                    end
                    s_addr += 4; s_left--; s_beat++;
                    if (s_left == 0) s_active = 0;
                end
                if (!(rvalid && !e_r)) begin
                    if (s_active && s_left > 0 && $urandom_range(0, 99) < rv_pct) begin
                        rvalid = 1'b1; rdata = mem(s_addr); rlast = (s_left == 1);
                        rresp = (s_beat == err_beat) ? 2'b10 : 2'b00;
                    end else begin
                        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
                    end
                end
            end
            m_ready = ($urandom_range(0, 99) < mr_pct);
            arready = ($urandom_range(0, 99) < ar_pct);
        end
    end

    task automatic issue_cmd(input logic [31:0] a, input int n);
        int a0;
        bit ok;
        a0 = acc_cnt; ok = 0;
        @(posedge clk); #2;
        cmd_valid = 1'b1; cmd_addr = a; cmd_beats = LW'(n);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); #1;
            if (acc_cnt != a0) ok = 1;
        end
        if (!ok) begin checks++; failures++; $display("FAIL cmd_accept_timeout actual=0 required=1"); end
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (done_cnt != d0) ok = 1;
            else begin @(negedge clk); #1; end
        end
        if (!ok) begin checks++; failures++; $display("FAIL done_timeout actual=0 required=1"); end
    endtask

    task automatic run_cmd(input logic [31:0] a, input int n);
        int d0;
        log_addr.delete(); log_len.delete(); lasts = 0;
        d0 = done_cnt;
        issue_cmd(a, n);
        wait_done(d0);
        chk("stream_left", stream_q.size(), 0);
        chk("ar_left", ar_addr_q.size(), 0);
        chk("last_count", lasts, (n > 0) ? 1 : 0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        repeat (3) @(posedge clk);
        #2;
        chk("rst_outs", {arvalid, rready, m_valid, m_last, busy, done, error}, 7'd0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        @(negedge clk); #2; rst = 1'b0;
        @(negedge clk); #1;
        chk("cmd_ready_after_reset", cmd_ready, 1);

        run_cmd(32'h4000_0000, 8);
        chk("t1_ar_count", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            chk("t1_addr", log_addr[0], 32'h4000_0000);
            chk("t1_arlen", log_len[0], 7);
        end

        run_cmd(32'h4000_0000, 40);
        chk("t2_ar_count", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk("t2_addr0", log_addr[0], 32'h4000_0000); chk("t2_len0", log_len[0], 15);
            chk("t2_addr1", log_addr[1], 32'h4000_0040); chk("t2_len1", log_len[1], 15);
            chk("t2_addr2", log_addr[2], 32'h4000_0080); chk("t2_len2", log_len[2], 7);
        end

        run_cmd(32'h4000_0FF0, 16);
        chk("t3_ar_count", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("t3_addr0", log_addr[0], 32'h4000_0FF0); chk("t3_len0", log_len[0], 3);
            chk("t3_addr1", log_addr[1], 32'h4000_1000); chk("t3_len1", log_len[1], 11);
        end

        rv_pct = 60; mr_pct = 50; ar_pct = 50;
        run_cmd({16'h4000, 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC}, 32);
        for (int k = 0; k < 8; k++) begin
            run_cmd({20'h40001, 12'($urandom_range(0, 4095)) & 12'hFFC}, $urandom_range(0, 70));
        end

        err_beat = 2;
        run_cmd(32'h4000_0200, 8);
        chk("err_at_done", error, 1);
        repeat (5) @(posedge clk);
        #2;
        chk("err_held", error, 1);
        err_beat = -1;
        run_cmd(32'h4000_0300, 4);
        chk("err_cleared", error, 0);

        rv_pct = 100; mr_pct = 100; ar_pct = 100;
        issue_cmd(32'h0000_2000, 16);
        for (int i = 0; i < 200 && beats_seen < 5; i++) begin
            @(posedge clk); #2;
        end
        chk("rst_mid_beats", beats_seen, 5);
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", {arvalid, rready, m_valid, m_last, busy, done, error}, 7'd0);
        chk("rst_mid_araddr", araddr, 0);
        chk("rst_mid_arlen", arlen, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2; rst = 1'b0;

        run_cmd(32'h0000_3000, 0);
        chk("zero_done_latency", done_cyc - acc_cyc, 1);
        chk("zero_no_ar", log_addr.size(), 0);
        run_cmd(32'h0000_3000, 4);
        chk("after_rst_ar_count", log_addr.size(), 1);
        if (log_addr.size() == 1) chk("after_rst_arlen", log_len[0], 3);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_burst_reader.md
# axi4_burst_reader

Parametrised AXI4 read-burst master that turns a single (address, beat count) command into a sequence of INCR read bursts and forwards the returned data as a ready/valid stream. Bursts are capped at MAX_BURST_LEN beats and never cross a 4 KB boundary. It replaces the fixed-length template master in the NPU's memory path. It sits between the NPU load controller, which issues commands, and the AXI interconnect toward DDR.

## Interface
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 32: AXI/stream data width; 32, 64 or 128.
- ID_WIDTH, 1: ARID width; ARID is driven constant 0.
- MAX_BURST_LEN, 16: maximum beats per burst; power of two, 1..256.
- LEN_WIDTH, 16: width of the command beat count.

Ports:
- m_axi_aclk  in  1  sole clock.
- m_axi_areset  in  1  asynchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_addr  in  ADDR_WIDTH  start byte address; must be aligned to DATA_WIDTH/8.
- cmd_beats  in  LEN_WIDTH  total beats to read; 0 is legal.
- m_axi_arid / araddr / arlen / arsize / arburst / arcache / arprot  out  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2 / 4 / 3  AR payload. arburst=INCR, arcache=4'b0011, arprot=0.
- m_axi_arvalid / m_axi_arready  out / in  1  AR handshake.
- m_axi_rid, rdata, rresp, rlast, rvalid  in  ID_WIDTH, DATA_WIDTH, 2, 1, 1  R channel.
- m_axi_rready  out  1.
- m_data  out  DATA_WIDTH  stream data, equal to rdata.
- m_valid / m_ready  out / in  1  stream handshake.
- m_last  out  1  final beat of the whole command.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky error flag.

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE
  - cmd_ready=1.
  - On cmd_valid: latch the address and remaining count (rem) and clear error.
  - Go to DONE if cmd_beats==0, otherwise to ADDR.
- ADDR
  - arvalid=1 and the AR payload is registered.
  - Burst length: len = min(rem, MAX_BURST_LEN, (4096 - addr[11:0]) >> log2(DATA_WIDTH/8)).
  - arlen = len-1; arsize = log2(DATA_WIDTH/8).
  - On arready: go to DATA and load the beat counter with len.
- DATA
  - m_valid = rvalid; rready = m_ready. No buffering; the stream is a pure pass-through.
  - Each handshake decrements the beat counter and rem.
  - m_last = rvalid & (rem==1).
  - On the rlast handshake: addr += len*(DATA_WIDTH/8); go to DONE if rem==0, else to ADDR.
- DONE: done=1 for one cycle, then go to IDLE.
- Error sources, all of which set error:
  - rresp != OKAY on any beat;
  - rlast with the beat counter != 1;
  - beat counter == 1 without rlast.
- On error the data is still forwarded and the burst still ends on rlast. The rem bookkeeping follows the actual handshakes.
- rid is ignored; this master has a single outstanding burst.

## Timing
- Reset values: state IDLE; arvalid, rready, m_valid, m_last, busy, done, error all 0; araddr and arlen 0. cmd_ready=1 once reset deasserts.
- Command accepted in cycle N: arvalid is high in cycle N+1.
- AR payload is stable while arvalid=1 and arready=0.
- Data path latency is 0 cycles (combinational rvalid→m_valid, m_ready→rready).
- Final-beat rlast handshake in cycle N: done=1 in cycle N+1, cmd_ready=1 in cycle N+2.
- Between bursts: rlast handshake in cycle N gives arvalid in cycle N+1, so there is one dead cycle per burst.
- cmd_beats==0: accepted in cycle N, done in cycle N+1, no AR issued.
- Reset asserted mid-operation: all outputs drop to their reset values immediately (asynchronous) and the transfer is abandoned. Draining the slave is out of scope.
- rem and the address are computed at full LEN_WIDTH and ADDR_WIDTH; address wrap past 2^ADDR_WIDTH is not checked.

## Structure
- Package axi4_pkg holds:
  - BURST_INCR=2'b01 and the RESP_OKAY/EXOKAY/SLVERR/DECERR codes;
  - AXI_4K_BYTES=4096;
  - function size_from_width(DATA_WIDTH);
  - the state enum typedef.
- One sub-module, axi4_burst_calc: a combinational len/arlen calculation from (addr, rem) that applies the 4 KB and MAX_BURST_LEN limits. It is reused later by the write master.

## Test plan
- addr=0x4000_0000, beats=8, DATA_WIDTH=32, MAX=16 → one AR with arlen=7; 8 stream beats; m_last on beat 8; done one cycle later.
- addr=0x4000_0000, beats=40 → three ARs: arlen 15, 15, 7 at 0x4000_0000, 0x4000_0040, 0x4000_0080; 40 beats; one m_last.
- addr=0x4000_0FF0, beats=16 → ARs with arlen=3 at 0x4000_0FF0, then arlen=11 at 0x4000_1000; no 4 KB crossing.
- beats=32 with random m_ready, slave rvalid random → rready mirrors m_ready every cycle; data sequence intact; no beats lost or duplicated.
- rresp=SLVERR on beat 3 of 8 → all 8 beats forwarded, error=1 at done and held; error cleared when the next command is accepted.
- Reset asserted during DATA after 5 of 16 beats → all outputs at reset values; after release, beats=0 gives done in the cycle after acceptance, then a normal 4-beat command completes.
